// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } muldivOp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } muldivState_e;
endpackage

// File: rtl/ex_muldiv_signfix.sv
// Combinational sign handling for signed MULT/DIV: operand magnitudes in,
// sign-corrected {HI,LO} out. Only instantiated when MULDIV_SIGNED_EN is set.
module ex_muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   rsVal,
  input  logic [WIDTH-1:0]   rtVal,
  input  logic [2*WIDTH-1:0] resIn,
  input  logic               resIsDiv,
  input  logic               negRes,
  input  logic               negRem,
  output logic [WIDTH-1:0]   absRs,
  output logic [WIDTH-1:0]   absRt,
  output logic               rsNeg,
  output logic               rtNeg,
  output logic [2*WIDTH-1:0] resOut
);
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_comb begin
    rsNeg = rsVal[WIDTH-1];
    rtNeg = rtVal[WIDTH-1];
    absRs = rsNeg ? -rsVal : rsVal;
    absRt = rtNeg ? -rtVal : rtVal;
    quot  = negRes ? -resIn[WIDTH-1:0] : resIn[WIDTH-1:0];
    rem   = negRem ? -resIn[2*WIDTH-1:WIDTH] : resIn[2*WIDTH-1:WIDTH];
    resOut = resIn;
    // Divide keeps HI/LO as independent remainder/quotient; multiply negates the full product.
    if (resIsDiv) resOut = {rem, quot};
    else if (negRes) resOut = -resIn;
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider holding HI/LO for the EX stage.
// Signed MULT/DIV handling is enabled by defining MULDIV_SIGNED_EN.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  // Handshake: start is only honoured in IDLE with flush low; the issuing
  // stage must keep start low while busy is high. done pulses once per result.
  muldivState_e       state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               isDiv;
  logic               rtZero;
  logic               busyQ;
  logic               doneQ;
  logic               divZeroQ;
  logic [WIDTH-1:0]   hiQ;
  logic [WIDTH-1:0]   loQ;

  logic [WIDTH-1:0]   latchA;
  logic [WIDTH-1:0]   latchB;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remTrial;
  logic [WIDTH:0]     remDiff;

`ifdef MULDIV_SIGNED_EN
  logic               signedOp;
  logic               negRes;
  logic               negRem;
  logic [WIDTH-1:0]   absRs;
  logic [WIDTH-1:0]   absRt;
  logic               rsNeg;
  logic               rtNeg;
  logic [2*WIDTH-1:0] fixedAcc;

  ex_muldiv_signfix #(.WIDTH(WIDTH)) uSignfix (
    .rsVal    (rs_in),
    .rtVal    (rt_in),
    .resIn    (acc),
    .resIsDiv (isDiv),
    .negRes   (negRes),
    .negRem   (negRem),
    .absRs    (absRs),
    .absRt    (absRt),
    .rsNeg    (rsNeg),
    .rtNeg    (rtNeg),
    .resOut   (fixedAcc)
  );

  assign latchA = op[1] ? absRs : rs_in;
  assign latchB = op[1] ? absRt : rt_in;
`else
  logic unusedOpSign;
  assign unusedOpSign = op[1];
  assign latchA = rs_in;
  assign latchB = rt_in;
`endif

  // acc holds {product} for multiply and {rem, quot} for divide.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    remTrial = acc[2*WIDTH-1:WIDTH-1];
    remDiff  = remTrial - {1'b0, opnd};
    if (isDiv) begin
      // Partial remainder stays below 2*divisor, so the sign bit of the
      // WIDTH+1-bit difference is a valid restore decision.
      if (!remDiff[WIDTH]) accNext = {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                 accNext = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) accNext = {mulSum, acc[WIDTH-1:1]};
      else        accNext = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      isDiv    <= 1'b0;
      rtZero   <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
`ifdef MULDIV_SIGNED_EN
      signedOp <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
      if (flush && state != S_IDLE) begin
        state <= S_IDLE;
        busyQ <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !flush) begin
              acc    <= {{WIDTH{1'b0}}, latchA};
              opnd   <= latchB;
              isDiv  <= op[0];
              rtZero <= (rt_in == '0);
              cnt    <= '0;
              busyQ  <= 1'b1;
              state  <= S_CALC;
`ifdef MULDIV_SIGNED_EN
              signedOp <= op[1];
              // A zero divisor keeps the all-ones quotient un-negated.
              negRes   <= op[1] & (rsNeg ^ rtNeg) & ~(op[0] & (rt_in == '0));
              negRem   <= op[1] & rsNeg;
`endif
            end
          end
          S_CALC: begin
            acc <= accNext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
              state <= signedOp ? S_FIX : S_DONE;
`else
              state <= S_DONE;
`endif
            end
          end
`ifdef MULDIV_SIGNED_EN
          S_FIX: begin
            acc   <= fixedAcc;
            state <= S_DONE;
          end
`endif
          S_DONE: begin
            hiQ   <= acc[2*WIDTH-1:WIDTH];
            loQ   <= acc[WIDTH-1:0];
            doneQ <= 1'b1;
            busyQ <= 1'b0;
            if (isDiv) divZeroQ <= rtZero;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = busyQ;
  assign done     = doneQ;
  assign div_zero = divZeroQ;
  assign hi_out   = hiQ;
  assign lo_out   = loQ;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic reference model plus literal pins.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rsIn = '0;
  logic [W-1:0] rtIn = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic         divZero;
  logic [W-1:0] hiOut;
  logic [W-1:0] loOut;

  int nVec = 0;
  int nMis = 0;
  bit chkEn = 1'b0;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_in    (rsIn),
    .rt_in    (rtIn),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (divZero),
    .hi_out   (hiOut),
    .lo_out   (loOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Results from plain arithmetic; timing as a simple countdown of edges.
  logic [2*W:0] expQ[$];  // {div_zero, hi, lo} of accepted operations
  bit           mBusy, mDone, mDz, mIsDiv;
  logic [W-1:0] mHi, mLo;
  int           mLeft;

  task automatic modelOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output bit isDivOut, output bit dz, output int lat);
    bit sgn;
    logic [63:0] prod;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    isDivOut = o[0];
    lat = sgn ? W + 2 : W + 1;
    dz = 1'b0;
    if (!o[0]) begin
      if (sgn) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     prod = 64'(a) * 64'(b);
      hi = prod[63:32];
      lo = prod[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else if (sgn) begin
      lo = W'($signed(a) / $signed(b));
      hi = W'($signed(a) % $signed(b));
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    logic [W-1:0] h, l;
    bit d, dz;
    int lat;
    if (!rst) begin
      mBusy = 0; mDone = 0; mDz = 0; mHi = '0; mLo = '0; mLeft = 0;
      expQ.delete();
    end else begin
      mDone = 0;
      if (mBusy) begin
        if (flush) begin
          mBusy = 0;
          void'(expQ.pop_back());
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            {d, mHi, mLo} = expQ[$];
            if (mIsDiv) mDz = d;
            mDone = 1;
            mBusy = 0;
          end
        end
      end else if (start && !flush) begin
        modelOp(op, rsIn, rtIn, h, l, mIsDiv, dz, lat);
        expQ.push_back({dz, h, l});
        mLeft = lat;
        mBusy = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (chkEn && rst) begin
      check("busy", 64'(busy), 64'(mBusy));
      check("done", 64'(done), 64'(mDone));
      check("hi_out", 64'(hiOut), 64'(mHi));
      check("lo_out", 64'(loOut), 64'(mLo));
      check("div_zero", 64'(divZero), 64'(mDz));
      if (start && busy) check("start_while_busy", 64'(1), 64'(0));
      if (done) begin
        if (expQ.size() == 0) check("done_without_op", 64'(1), 64'(0));
        else begin
          e = expQ.pop_front();
          check("sb_hi", 64'(hiOut), 64'(e[2*W-1:W]));
          check("sb_lo", 64'(loOut), 64'(e[W-1:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rsIn = a; rtIn = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic runPin(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo,
                        input int eLat);
    int lat;
    issue(o, a, b);
    waitDone(lat);
    check({name, "_lat"}, 64'(lat), 64'(eLat));
    check({name, "_hi"}, 64'(hiOut), 64'(eHi));
    check({name, "_lo"}, 64'(loOut), 64'(eLo));
  endtask

  initial begin
    int lat;
    #12 rst = 1'b1;
    chkEn = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hiOut), 64'(0));
    check("reset_lo", 64'(loOut), 64'(0));

    runPin("multu_7x6", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 33);
    runPin("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    runPin("multu_msb", OP_MULTU, 32'h80000000, 32'd2, 32'd1, 32'd0, 33);
    runPin("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    check("divu_100_7_dz", 64'(divZero), 64'(0));
    runPin("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
    check("divu_5_0_dz", 64'(divZero), 64'(1));
    runPin("multu_keeps_dz", OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 33);
    check("multu_keeps_dz_flag", 64'(divZero), 64'(1));

    // Flush mid-divide: no result, previous HI/LO and flag retained.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi", 64'(hiOut), 64'(0));
    check("flush_lo", 64'(loOut), 64'(81));
    check("flush_dz", 64'(divZero), 64'(1));
    runPin("divu_reissue", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    check("divu_reissue_dz", 64'(divZero), 64'(0));

    // Flush and start together in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; rsIn = 32'd3; rtIn = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));

    // Asynchronous reset mid-multiply.
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_hi", 64'(hiOut), 64'(0));
    check("arst_lo", 64'(loOut), 64'(0));
    check("arst_dz", 64'(divZero), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    runPin("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33);

    runPin("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 33);
`ifdef MULDIV_SIGNED_EN
    runPin("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    runPin("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
    runPin("div_m5_0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 34);
    check("div_m5_0_dz", 64'(divZero), 64'(1));
`else
    runPin("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 33);
    runPin("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1, 33);
`endif
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(expQ.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    nMis++;
    $display("FAIL global_timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
